// File: rtl/gcm_pkg.sv
// gcm_pkg: shared widths, FSM states and byte-count helpers for the GCM counter path
package gcm_pkg;
  localparam int DATA_WIDTH = 128;
  localparam int S = 32;
  typedef enum logic [2:0] {IDLE, J0_REQ, WAIT_CT, KS_REQ, OUT} state_t;
  function automatic logic [4:0] norm_bytes(input logic [4:0] b);
    return (b == 5'd0 || b > 5'd16) ? 5'd16 : b;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [4:0] n);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++)
      if (5'(i) < n) m[DATA_WIDTH-1-8*i -: 8] = 8'hff;
    return m;
  endfunction
endpackage

// File: rtl/ctr_inc_s.sv
// ctr_inc_s: increments the low S bits of a counter block modulo 2^S
module ctr_inc_s #(
  parameter int DATA_WIDTH = 128,
  parameter int S = 32
) (
  input  logic [DATA_WIDTH-1:0] blk,
  output logic [DATA_WIDTH-1:0] nxt
);
  assign nxt = {blk[DATA_WIDTH-1:S], blk[S-1:0] + S'(1)};
endmodule

// File: rtl/gctr_decrypt.sv
// gctr_decrypt: GCM counter-mode decrypt engine sharing an external AES core
module gctr_decrypt
  import gcm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] icb_in,
  input  logic                  ct_valid,
  output logic                  ct_ready,
  input  logic [DATA_WIDTH-1:0] ct_data,
  input  logic                  ct_last,
  input  logic [4:0]            ct_bytes,
  output logic                  pt_valid,
  input  logic                  pt_ready,
  output logic [DATA_WIDTH-1:0] pt_data,
  output logic                  pt_last,
  output logic [4:0]            pt_bytes,
  output logic                  ciph_req,
  output logic [DATA_WIDTH-1:0] ciph_block,
  input  logic                  ciph_ack,
  input  logic [DATA_WIDTH-1:0] ciph_result,
  output logic [DATA_WIDTH-1:0] ek_j0,
  output logic                  ek_j0_valid,
  output logic                  busy
);
  state_t state;
  logic [DATA_WIDTH-1:0] counter, counter_nxt, ct_reg;
  logic last_reg;
  logic [4:0] bytes_reg;
  ctr_inc_s #(.DATA_WIDTH(DATA_WIDTH), .S(S)) u_inc (.blk(counter), .nxt(counter_nxt));
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      ct_reg      <= '0;
      last_reg    <= 1'b0;
      bytes_reg   <= '0;
      ct_ready    <= 1'b0;
      pt_valid    <= 1'b0;
      pt_data     <= '0;
      pt_last     <= 1'b0;
      pt_bytes    <= '0;
      ciph_req    <= 1'b0;
      ciph_block  <= '0;
      ek_j0       <= '0;
      ek_j0_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          counter     <= icb_in;
          ciph_block  <= icb_in;
          ciph_req    <= 1'b1;
          ek_j0_valid <= 1'b0;
          busy        <= 1'b1;
          state       <= J0_REQ;
        end
        J0_REQ: if (ciph_ack) begin
          ek_j0       <= ciph_result;
          ek_j0_valid <= 1'b1;
          counter     <= counter_nxt;
          ciph_req    <= 1'b0;
          ct_ready    <= 1'b1;
          state       <= WAIT_CT;
        end
        WAIT_CT: if (ct_valid) begin
          ct_reg     <= ct_data;
          last_reg   <= ct_last;
          // partial blocks only count on the final block
          bytes_reg  <= ct_last ? norm_bytes(ct_bytes) : 5'd16;
          ct_ready   <= 1'b0;
          ciph_req   <= 1'b1;
          ciph_block <= counter;
          state      <= KS_REQ;
        end
        KS_REQ: if (ciph_ack) begin
          pt_data  <= (ct_reg ^ ciph_result) & byte_mask(bytes_reg);
          pt_last  <= last_reg;
          pt_bytes <= bytes_reg;
          pt_valid <= 1'b1;
          ciph_req <= 1'b0;
          state    <= OUT;
        end
        OUT: if (pt_ready) begin
          pt_valid <= 1'b0;
          pt_last  <= 1'b0;
          if (last_reg) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            counter  <= counter_nxt;
            ct_ready <= 1'b1;
            state    <= WAIT_CT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gctr_decrypt.sv
// tb_gctr_decrypt: directed vectors for gctr_decrypt with a scripted AES responder
module tb_gctr_decrypt;
  logic clk = 0, rst = 1, start = 0, ct_valid = 0, ct_last = 0, pt_ready = 0;
  logic [127:0] icb_in = '0, ct_data = '0, ciph_result, pt_data, ciph_block, ek_j0;
  logic [4:0] ct_bytes = '0, pt_bytes;
  logic ct_ready, pt_valid, pt_last, ciph_req, ciph_ack, ek_j0_valid, busy;
  int errors = 0, checks = 0, ack_delay = 0, req_count = 0;
  localparam logic [127:0] EK1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] EK2 = 128'h0388dace60b6a392f328c2b971b2fe78;

  gctr_decrypt dut (
    .clk(clk), .rst(rst), .start(start), .icb_in(icb_in),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last), .ct_bytes(ct_bytes),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last), .pt_bytes(pt_bytes),
    .ciph_req(ciph_req), .ciph_block(ciph_block), .ciph_ack(ciph_ack), .ciph_result(ciph_result),
    .ek_j0(ek_j0), .ek_j0_valid(ek_j0_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Known AES-128 (K=0) results for counters 1 and 2; other blocks get a stand-in cipher
  function automatic logic [127:0] aes0(input logic [127:0] b);
    if (b == 128'h1) return EK1;
    if (b == 128'h2) return EK2;
    return {b[63:0], b[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] keep(input int n);
    return ~128'h0 << (8 * (16 - n));
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    ciph_ack = 0;
    ciph_result = '0;
    forever begin
      @(negedge clk);
      ciph_ack = 0;
      if (ciph_req) begin
        for (int k = 0; k < ack_delay && ciph_req; k++) @(negedge clk);
        if (ciph_req) begin
          ciph_ack = 1;
          ciph_result = aes0(ciph_block);
          req_count++;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, " ct_ready"}, ct_ready, 0);
    check({tag, " pt_valid"}, pt_valid, 0);
    check({tag, " pt_last"}, pt_last, 0);
    check({tag, " ciph_req"}, ciph_req, 0);
    check({tag, " ek_j0_valid"}, ek_j0_valid, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " pt_data"}, pt_data, 0);
    check({tag, " ek_j0"}, ek_j0, 0);
    check({tag, " ciph_block"}, ciph_block, 0);
    check({tag, " pt_bytes"}, pt_bytes, 0);
  endtask

  task automatic start_msg(input logic [127:0] j0);
    start = 1;
    icb_in = j0;
    @(negedge clk);
    start = 0;
    check("j0 req", ciph_req, 1);
    check("j0 block", ciph_block, j0);
    check("ek_j0_valid cleared", ek_j0_valid, 0);
  endtask

  task automatic send_block(input logic [127:0] d, input logic l, input logic [4:0] n, input logic [127:0] ctr);
    for (int i = 0; i < 50 && !ct_ready; i++) @(negedge clk);
    check("ct_ready wait", ct_ready, 1);
    ct_valid = 1;
    ct_data = d;
    ct_last = l;
    ct_bytes = n;
    @(negedge clk);
    ct_valid = 0;
    check("ks block", ciph_block, ctr);
    check("ct_ready in ks", ct_ready, 0);
  endtask

  task automatic recv_block(input logic [127:0] d, input logic l, input logic [4:0] n,
                            input logic [127:0] ctr, input int hold);
    logic ok = 1;
    for (int i = 0; i < 50 && !pt_valid; i++) begin
      ok &= (!ciph_req || ciph_block == ctr) && !ct_ready;
      @(negedge clk);
    end
    check("ks hold stable", ok, 1);
    check("pt_valid wait", pt_valid, 1);
    check("pt_data", pt_data, d);
    check("pt_last", pt_last, l);
    check("pt_bytes", pt_bytes, n);
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ok &= pt_valid && pt_data == d && pt_last == l && pt_bytes == n && !ct_ready;
    end
    check("pt backpressure stable", ok, 1);
    pt_ready = 1;
    @(negedge clk);
    pt_ready = 0;
    check("pt_valid drop", pt_valid, 0);
  endtask

  initial begin
    logic [127:0] j0w, jb;
    int rc;
    repeat (2) @(negedge clk);
    rst = 0;
    check_reset("reset");

    // J0 = 1, single full block; K=0 GCM vectors give all-zero plaintext
    start_msg(128'h1);
    send_block(EK2, 1, 5'd16, 128'h2);
    check("ek_j0", ek_j0, EK1);
    check("ek_j0_valid", ek_j0_valid, 1);
    recv_block(128'h0, 1, 5'd16, 128'h2, 0);
    check("busy after last", busy, 0);
    check("ek_j0_valid held", ek_j0_valid, 1);

    // partial final blocks
    start_msg(128'h1);
    send_block(EK2, 1, 5'd5, 128'h2);
    recv_block(128'h0, 1, 5'd5, 128'h2, 0);
    start_msg(128'h1);
    send_block(~128'h0, 1, 5'd5, 128'h2);
    recv_block(128'hfc7725319f0000000000000000000000, 1, 5'd5, 128'h2, 0);
    start_msg(128'h1);
    send_block(~128'h0, 1, 5'd0, 128'h2);
    recv_block(~EK2, 1, 5'd16, 128'h2, 0);

    // low-word wrap; mid-message byte count is ignored
    j0w = 128'hcafebabe_deadbeef_01234567_fffffffe;
    start_msg(j0w);
    send_block(128'h1111, 0, 5'd3, 128'hcafebabe_deadbeef_01234567_ffffffff);
    check("ek_j0 wrap", ek_j0, aes0(j0w));
    recv_block(128'h1111 ^ aes0(128'hcafebabe_deadbeef_01234567_ffffffff), 0, 5'd16,
               128'hcafebabe_deadbeef_01234567_ffffffff, 0);
    send_block(128'h2222, 1, 5'd20, 128'hcafebabe_deadbeef_01234567_00000000);
    recv_block(128'h2222 ^ aes0(128'hcafebabe_deadbeef_01234567_00000000), 1, 5'd16,
               128'hcafebabe_deadbeef_01234567_00000000, 0);

    // slow AES, pt backpressure, and a start pulse while busy
    ack_delay = 7;
    rc = req_count;
    jb = 128'h0102030405060708090a0b0c_00000010;
    start_msg(jb);
    send_block(128'habcd, 0, 5'd16, jb + 1);
    recv_block((128'habcd ^ aes0(jb + 1)), 0, 5'd16, jb + 1, 4);
    start = 1;
    icb_in = 128'h77;
    @(negedge clk);
    start = 0;
    send_block(128'h1234, 1, 5'd7, jb + 2);
    recv_block((128'h1234 ^ aes0(jb + 2)) & keep(7), 1, 5'd7, jb + 2, 4);
    check("ek_j0 after busy start", ek_j0, aes0(jb));
    check("aes request count", 128'(req_count - rc), 3);

    // reset while waiting for a keystream block
    start_msg(128'h1);
    send_block(EK2, 1, 5'd16, 128'h2);
    check("in ks_req", ciph_req, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset("mid reset");
    repeat (10) @(negedge clk);
    check("no output after reset", pt_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
